// File: rtl/matrix_add_stream.sv
// Streaming fixed-point matrix add/sub/accumulate/ReLU, LANES elements per beat.
// Define MADD_SATURATE_EN to clamp overflowing elements instead of wrapping them.
module matrix_add_stream #(
    parameter int H           = 8,
    parameter int W           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int LANES       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   mode,
    input  logic                         acc_clr,
    input  logic [H*W*DATA_WIDTH-1:0]    a,
    input  logic [H*W*DATA_WIDTH-1:0]    b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [H*W*DATA_WIDTH-1:0]    y,
    output logic                         ovf
);

    localparam int N     = H * W;
    localparam int BEATS = N / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VEC_W = N * DATA_WIDTH;

    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_RELU = 2'b11;

`ifdef MADD_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    // FRACT_WIDTH does not affect the arithmetic; it is only range-checked here.
    generate
        if ((N % LANES) != 0 || FRACT_WIDTH < 0 || FRACT_WIDTH > DATA_WIDTH) begin : g_bad_cfg
            $error("matrix_add_stream: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [VEC_W-1:0]   a_q, a_d;
    logic [VEC_W-1:0]   b_q, b_d;
    logic [VEC_W-1:0]   acc_q, acc_d;
    logic [VEC_W-1:0]   y_q, y_d;
    logic [1:0]         mode_q, mode_d;
    logic               clr_q, clr_d;
    logic               ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            mode_q  <= '0;
            clr_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            clr_q   <= clr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        logic [DATA_WIDTH-1:0] op_x;
        logic [DATA_WIDTH-1:0] op_y;
        logic [DATA_WIDTH:0]   sum;
        logic [DATA_WIDTH-1:0] res;
        logic                  lane_ovf;
        int                    idx;

        state_d  = state_q;
        beat_d   = beat_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        y_d      = y_q;
        mode_d   = mode_q;
        clr_d    = clr_q;
        ovf_d    = ovf_q;
        op_x     = '0;
        op_y     = '0;
        sum      = '0;
        res      = '0;
        lane_ovf = 1'b0;
        idx      = 0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    clr_d   = acc_clr;
                    beat_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    idx = int'(beat_q) * LANES + l;
                    if (mode_q == MODE_ACC) begin
                        op_x = clr_q ? '0 : acc_q[idx*DATA_WIDTH +: DATA_WIDTH];
                        op_y = a_q[idx*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        op_x = a_q[idx*DATA_WIDTH +: DATA_WIDTH];
                        op_y = b_q[idx*DATA_WIDTH +: DATA_WIDTH];
                    end

                    // One guard bit: overflow shows up as disagreement of the top two bits.
                    if (mode_q == MODE_SUB) begin
                        sum = {op_x[DATA_WIDTH-1], op_x} - {op_y[DATA_WIDTH-1], op_y};
                    end else begin
                        sum = {op_x[DATA_WIDTH-1], op_x} + {op_y[DATA_WIDTH-1], op_y};
                    end
                    lane_ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
                    res      = sum[DATA_WIDTH-1:0];
`ifdef MADD_SATURATE_EN
                    if (lane_ovf) begin
                        res = sum[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
                    end
`endif
                    if (mode_q == MODE_RELU && res[DATA_WIDTH-1]) begin
                        res = '0;
                    end

                    y_d[idx*DATA_WIDTH +: DATA_WIDTH] = res;
                    if (mode_q == MODE_ACC) begin
                        acc_d[idx*DATA_WIDTH +: DATA_WIDTH] = res;
                    end
                    ovf_d = ovf_d | lane_ovf;
                end

                if (beat_q == CNT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = HOLD;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end

            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign y         = y_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_matrix_add_stream.sv
// Scoreboard bench for matrix_add_stream on a 2x2 matrix, 16-bit elements, 2 lanes.
// Expected results come from an integer reference model; a monitor pops and compares.
module tb_matrix_add_stream;

    localparam int H     = 2;
    localparam int W     = 2;
    localparam int DW    = 16;
    localparam int LANES = 2;
    localparam int N     = H * W;
    localparam int BEATS = N / LANES;
    localparam int VEC_W = N * DW;

    typedef struct packed {
        logic [VEC_W-1:0] y;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic             acc_clr;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] y;
    logic             ovf;

    exp_t             sb_q[$];
    logic [DW-1:0]    model_acc[N];
    int               checks = 0;
    int               errors = 0;

    matrix_add_stream #(
        .H(H), .W(W), .DATA_WIDTH(DW), .FRACT_WIDTH(8), .LANES(LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if the values differ.
    task automatic compareValue(input string name, input logic [VEC_W-1:0] got,
                                input logic [VEC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] fill(input logic [DW-1:0] v);
        return {N{v}};
    endfunction

    // Reference: each element is plain integer arithmetic followed by range handling.
    function automatic exp_t model_job(input logic [VEC_W-1:0] av, input logic [VEC_W-1:0] bv,
                                       input logic [1:0] m, input logic clr);
        exp_t          e;
        int            x;
        int            z;
        int            s;
        logic [DW-1:0] r;
        e.y   = '0;
        e.ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            x = $signed(av[k*DW +: DW]);
            z = $signed(bv[k*DW +: DW]);
            case (m)
                2'b00:   s = x + z;
                2'b01:   s = x - z;
                2'b10:   s = (clr ? 0 : int'($signed(model_acc[k]))) + x;
                default: s = x + z;
            endcase
            if (s > 32767 || s < -32768) e.ovf = 1'b1;
`ifdef MADD_SATURATE_EN
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`endif
            r = s[DW-1:0];
            if (m == 2'b11 && $signed(r) < 0) r = '0;
            if (m == 2'b10) model_acc[k] = r;
            e.y[k*DW +: DW] = r;
        end
        return e;
    endfunction

    // Waits for in_ready, presents one job for exactly one accepting edge.
    task automatic applyStimulus(input logic [VEC_W-1:0] av, input logic [VEC_W-1:0] bv,
                                 input logic [1:0] m, input logic clr, input bit expect_out);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            compareValue("in_ready_wait", {{(VEC_W-1){1'b0}}, in_ready}, 1);
            return;
        end
        if (expect_out) sb_q.push_back(model_job(av, bv, m, clr));
        a        = av;
        b        = bv;
        mode     = m;
        acc_clr  = clr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        mode     = 2'($urandom_range(0, 3));
        acc_clr  = 1'($urandom_range(0, 1));
    endtask

    // Measures accept-to-out_valid latency, then lets the handshake complete if out_ready is high.
    task automatic checkOutput();
        int lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        compareValue("latency", VEC_W'(lat), VEC_W'(BEATS));
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got y=%h with no job outstanding, required none", y);
            end else begin
                e = sb_q.pop_front();
                compareValue("y", y, e.y);
                compareValue("ovf", {{(VEC_W-1){1'b0}}, ovf}, {{(VEC_W-1){1'b0}}, e.ovf});
            end
        end
    end

    initial begin
        exp_t hold_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 2'b00;
        acc_clr   = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) model_acc[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        compareValue("rst_in_ready", {{(VEC_W-1){1'b0}}, in_ready}, 1);
        compareValue("rst_out_valid", {{(VEC_W-1){1'b0}}, out_valid}, 0);
        compareValue("rst_ovf", {{(VEC_W-1){1'b0}}, ovf}, 0);
        compareValue("rst_y", y, '0);

        $display("[TB] directed arithmetic jobs");
        applyStimulus(fill(16'h0100), fill(16'h0080), 2'b00, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(fill(16'h0080), fill(16'h0100), 2'b01, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(fill(16'h0080), fill(16'hFF00), 2'b11, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(fill(16'h7F00), fill(16'h0200), 2'b00, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(fill(16'h8000), fill(16'h0001), 2'b01, 1'b0, 1'b1);
        checkOutput();

        $display("[TB] accumulate sequence with intervening add");
        applyStimulus(fill(16'h0100), fill(16'h5555), 2'b10, 1'b1, 1'b1);
        checkOutput();
        applyStimulus(fill(16'h0100), fill(16'h1234), 2'b10, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(fill(16'h0300), fill(16'h0400), 2'b00, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(fill(16'h0100), fill(16'h0000), 2'b10, 1'b0, 1'b1);
        checkOutput();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 2'b00, 1'b0, 1'b1);
        checkOutput();
        hold_exp = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            compareValue("hold_y", y, hold_exp.y);
            compareValue("hold_in_ready", {{(VEC_W-1){1'b0}}, in_ready}, 0);
            compareValue("hold_out_valid", {{(VEC_W-1){1'b0}}, out_valid}, 1);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset during RUN");
        applyStimulus(fill(16'h1234), fill(16'h0101), 2'b00, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) model_acc[k] = '0;
        compareValue("abort_out_valid", {{(VEC_W-1){1'b0}}, out_valid}, 0);
        compareValue("abort_in_ready", {{(VEC_W-1){1'b0}}, in_ready}, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            compareValue("abort_no_output", {{(VEC_W-1){1'b0}}, out_valid}, 0);
        end
        applyStimulus(fill(16'h0100), fill(16'h7777), 2'b10, 1'b0, 1'b1);
        checkOutput();

        $display("[TB] randomized jobs");
        for (int j = 0; j < 40; j++) begin
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom},
                          2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b1);
            checkOutput();
        end

        repeat (4) @(posedge clk);
        #1;
        compareValue("scoreboard_drained", VEC_W'(sb_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
